// File: rtl/hack_alu.sv
// hack_alu: registered 16-bit Hack ALU.
// Operands pass through the zero/invert stages, then through an add or an AND,
// and finally through an optional output invert. The result and its zero and
// negative flags are captured in an output register, so latency is one cycle.
module hack_alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  input  logic        in_valid,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng,
  output logic        out_valid
);

  // Operand conditioning stages, one signal per stage of the ALU.
  logic [15:0] xa;
  logic [15:0] xb;
  logic [15:0] ya;
  logic [15:0] yb;
  logic [15:0] and_r;
  logic [15:0] sum_r;
  logic [15:0] fn_r;
  logic [15:0] res;

  // Next-state values for the output register.
  logic [15:0] out_next;
  logic        zr_next;
  logic        ng_next;

  // Output register state.
  logic [15:0] out_reg;
  logic        zr_reg;
  logic        ng_reg;
  logic        valid_reg;

  // Per-bit zero/invert stages, the AND function, function select and the
  // final invert. Zeroing happens before inversion, so zx=1,nx=1 gives all ones.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_bit
      assign xa[gi]    = x[gi] & ~zx;
      assign xb[gi]    = xa[gi] ^ nx;
      assign ya[gi]    = y[gi] & ~zy;
      assign yb[gi]    = ya[gi] ^ ny;
      assign and_r[gi] = xb[gi] & yb[gi];
      assign fn_r[gi]  = f ? sum_r[gi] : and_r[gi];
      assign res[gi]   = fn_r[gi] ^ no;
    end
  endgenerate

  // Modulo 2^16 addition; the carry out is intentionally dropped.
  assign sum_r = xb + yb;

  // Flags are taken from the final result, after the output invert.
  always_comb begin
    out_next = res;
    zr_next  = (res == 16'h0000);
    ng_next  = res[15];
  end

  // Output register: reset wins, a valid operation loads, otherwise hold data
  // and drop the valid strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_reg   <= 16'h0000;
      zr_reg    <= 1'b1;
      ng_reg    <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= in_valid;
      if (in_valid) begin
        out_reg <= out_next;
        zr_reg  <= zr_next;
        ng_reg  <= ng_next;
      end
    end
  end

  assign out       = out_reg;
  assign zr        = zr_reg;
  assign ng        = ng_reg;
  assign out_valid = valid_reg;

endmodule

// File: tb/tb_hack_alu.sv
// tb_hack_alu: scoreboard bench for hack_alu. The driver pushes the expected
// post-edge output state for every cycle; the monitor pops and compares.
module tb_hack_alu;

  logic        clk;
  logic        reset;
  logic [15:0] x;
  logic [15:0] y;
  logic        zx, nx, zy, ny, f, no;
  logic        in_valid;
  logic [15:0] out;
  logic        zr;
  logic        ng;
  logic        out_valid;

  typedef struct {
    logic        valid;
    logic [15:0] out;
    logic        zr;
    logic        ng;
  } exp_t;

  exp_t exp_q[$];

  int n_vectors;
  int n_miscompares;
  int cycle;

  // Model of the output register contents when nothing new is loaded.
  logic [15:0] held_out;
  logic        held_zr;
  logic        held_ng;

  logic [5:0] canon [18];

  hack_alu dut (
    .clk       (clk),
    .reset     (reset),
    .x         (x),
    .y         (y),
    .zx        (zx),
    .nx        (nx),
    .zy        (zy),
    .ny        (ny),
    .f         (f),
    .no        (no),
    .in_valid  (in_valid),
    .out       (out),
    .zr        (zr),
    .ng        (ng),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: Hack ALU rules written with plain integer arithmetic.
  function automatic logic [15:0] ref_alu(input logic [15:0] xi, input logic [15:0] yi,
                                          input logic [5:0] c);
    int a;
    int b;
    int r;
    a = c[5] ? 0 : int'(xi);
    if (c[4]) a = 65535 - a;
    b = c[3] ? 0 : int'(yi);
    if (c[2]) b = 65535 - b;
    if (c[1]) r = (a + b) % 65536;
    else      r = a & b;
    if (c[0]) r = 65535 - r;
    return r[15:0];
  endfunction

  // Drive one cycle of stimulus and push the expected state after the next edge.
  task automatic apply(input logic rst, input logic vld, input logic [15:0] xi,
                       input logic [15:0] yi, input logic [5:0] c,
                       input logic use_exp, input logic [15:0] exp_out);
    exp_t e;
    logic [15:0] v;
    reset    = rst;
    in_valid = vld;
    x        = xi;
    y        = yi;
    {zx, nx, zy, ny, f, no} = c;
    if (rst) begin
      held_out = 16'h0000;
      held_zr  = 1'b1;
      held_ng  = 1'b0;
      e.valid  = 1'b0;
    end else if (vld) begin
      v        = use_exp ? exp_out : ref_alu(xi, yi, c);
      held_out = v;
      held_zr  = (v == 16'h0000);
      held_ng  = v[15];
      e.valid  = 1'b1;
    end else begin
      e.valid  = 1'b0;
    end
    e.out = held_out;
    e.zr  = held_zr;
    e.ng  = held_ng;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: one comparison per clock edge against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      n_vectors++;
      if (exp_q.size() == 0) begin
        n_miscompares++;
        $display("FAIL cyc=%0d scoreboard_empty got valid=%b out=%h", cycle, out_valid, out);
      end else begin
        e = exp_q.pop_front();
        if (out_valid !== e.valid || out !== e.out || zr !== e.zr || ng !== e.ng) begin
          n_miscompares++;
          $display("FAIL cyc=%0d result got valid=%b out=%h zr=%b ng=%b want valid=%b out=%h zr=%b ng=%b",
                   cycle, out_valid, out, zr, ng, e.valid, e.out, e.zr, e.ng);
        end else begin
          $display("vec %0d valid=%b out=%h zr=%b ng=%b ok", cycle, out_valid, out, zr, ng);
        end
      end
    end
  end

  // Driver: directed test-plan vectors, then randomized traffic.
  initial begin
    logic [5:0]  c;
    logic [15:0] rx;
    logic [15:0] ry;
    logic        rrst;
    logic        rvld;
    canon = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
              6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
              6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};
    n_vectors     = 0;
    n_miscompares = 0;
    cycle         = 0;
    held_out      = 16'h0000;
    held_zr       = 1'b1;
    held_ng       = 1'b0;

    apply(1'b1, 1'b1, 16'h0001, 16'h0005, 6'b000010, 1'b0, 16'h0);
    apply(1'b1, 1'b1, 16'h0001, 16'h0005, 6'b000010, 1'b0, 16'h0);
    apply(1'b0, 1'b1, 16'h0001, 16'h0005, 6'b010011, 1'b1, 16'hFFFC);
    apply(1'b0, 1'b1, 16'h0001, 16'h0005, 6'b000010, 1'b1, 16'h0006);
    apply(1'b0, 1'b1, 16'h0001, 16'h0005, 6'b011111, 1'b1, 16'h0002);
    apply(1'b0, 1'b1, 16'h0001, 16'h0005, 6'b101010, 1'b1, 16'h0000);
    apply(1'b0, 1'b1, 16'h0001, 16'h0005, 6'b111111, 1'b1, 16'h0001);
    apply(1'b0, 1'b1, 16'h0001, 16'h0005, 6'b111010, 1'b1, 16'hFFFF);
    apply(1'b0, 1'b1, 16'h0001, 16'h0005, 6'b000000, 1'b1, 16'h0001);
    apply(1'b0, 1'b1, 16'h0001, 16'h0005, 6'b010101, 1'b1, 16'h0005);
    apply(1'b0, 1'b1, 16'h0001, 16'h0005, 6'b000111, 1'b1, 16'h0004);
    apply(1'b0, 1'b1, 16'hFFFF, 16'h0001, 6'b000010, 1'b1, 16'h0000);
    apply(1'b0, 1'b0, 16'h1234, 16'h5678, 6'b000010, 1'b0, 16'h0);
    apply(1'b0, 1'b0, 16'h8000, 16'h0001, 6'b111111, 1'b0, 16'h0);
    apply(1'b0, 1'b1, 16'h8000, 16'h0001, 6'b000010, 1'b1, 16'h8001);
    apply(1'b0, 1'b0, 16'h0000, 16'h0000, 6'b101010, 1'b0, 16'h0);

    for (int i = 0; i < 400; i++) begin
      rx   = 16'($urandom);
      ry   = 16'($urandom);
      if ($urandom_range(0, 7) == 0) rx = 16'hFFFF;
      if ($urandom_range(0, 7) == 0) ry = 16'h0000;
      if ($urandom_range(0, 1) == 0) c = canon[$urandom_range(0, 17)];
      else                           c = 6'($urandom);
      rrst = ($urandom_range(0, 31) == 0);
      rvld = ($urandom_range(0, 3) != 0);
      apply(rrst, rvld, rx, ry, c, 1'b0, 16'h0);
    end

    if (exp_q.size() != 0) begin
      n_miscompares++;
      $display("FAIL leftover_expectations got %0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/hack_alu.md
# hack_alu

Registered 16-bit Hack-platform arithmetic/logic unit, used as the compute core of the Hack CPU. It applies the six Hack control bits (zx, nx, zy, ny, f, no) to two 16-bit operands and returns the result with zero and negative flags. The result and flags are captured in an output register, giving a fixed one-cycle latency. A valid strobe accompanies each result.

## Interface
Parameters:
- none; the datapath width is fixed at 16 bits.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- x  in  16  operand X.
- y  in  16  operand Y.
- zx  in  1  force X to 0.
- nx  in  1  bitwise-invert X, applied after zx.
- zy  in  1  force Y to 0.
- ny  in  1  bitwise-invert Y, applied after zy.
- f  in  1  function select: 1 = X+Y, 0 = X&Y.
- no  in  1  bitwise-invert the function result.
- in_valid  in  1  operands and control bits are valid this cycle.
- out  out  16  registered result.
- zr  out  1  registered flag: 1 iff out == 16'h0000.
- ng  out  1  registered flag: 1 iff out[15] == 1, i.e. two's-complement negative.
- out_valid  out  1  out, zr and ng hold a fresh result.

## Operation
- Combinational path, evaluated in this order:
  - xa = zx ? 0 : x.
  - xb = nx ? ~xa : xa.
  - ya = zy ? 0 : y.
  - yb = ny ? ~ya : ya.
  - r = f ? (xb + yb) : (xb & yb).
  - res = no ? ~r : r.
- Addition is 16-bit unsigned modulo 2^16. The carry out is discarded and there is no overflow flag.
- Flags are computed from the final res, after the no stage.
  - zr = (res == 0).
  - ng = res[15].
- Canonical Hack encodings (zx nx zy ny f no) all must work. Examples: 101010 = 0; 111111 = 1; 111010 = -1; 011111 = x+1; 000010 = x+y; 010011 = x-y; 000111 = y-x; 000000 = x&y; 010101 = x|y.
- Non-canonical encodings are legal and are computed exactly by the six-stage rule above; no error is signalled.
- Output register:
  - When in_valid = 1, out/zr/ng load res and its flags, and out_valid is set to 1.
  - When in_valid = 0, out/zr/ng hold their previous values and out_valid is set to 0.

## Timing
- Latency: exactly 1 cycle. Inputs sampled at rising edge N appear on out/zr/ng/out_valid after edge N.
- Throughput: one operation per cycle. No backpressure and no stall.
- Reset has priority over in_valid. While reset = 1 at an edge, the outputs take their reset values:
  - out = 16'h0000
  - zr = 1
  - ng = 0
  - out_valid = 0
- Reset mid-stream: any operation sampled with reset = 1 is discarded. The first valid result appears one cycle after the first edge with reset = 0 and in_valid = 1.
- Outputs are purely registered. There is no combinational path from the inputs to the outputs.

## Test plan
- Reset: assert reset for 2 cycles with in_valid = 1 -> out = 0000, zr = 1, ng = 0, out_valid = 0 throughout.
- Subtract, one cycle later: x = 0001, y = 0005, code 010011 -> out = FFFC, zr = 0, ng = 1, out_valid = 1.
- Add: code 000010 -> out = 0006, zr = 0, ng = 0.
- Increment: code 011111 -> out = 0002.
- Constants: code 101010 -> out = 0000, zr = 1; code 111111 -> out = 0001; code 111010 -> out = FFFF, ng = 1.
- Logic, wrap and hold:
  - x = 0001, y = 0005: code 000000 -> out = 0001; code 010101 -> out = 0005.
  - x = FFFF, y = 0001, code 000010 -> out = 0000, zr = 1 (carry dropped).
  - Then in_valid = 0 -> out holds 0000, out_valid = 0.
